transpose_pingpong_buffer: RTL and testbench

- Parametrised successor to the single-port 64x24 block RAM used between the row and column 1-D DCT passes.
- Holds two N×N blocks of DATA_W-bit coefficients in ping-pong banks.
- Accepts a block row-major on a valid/ready write stream and returns it column-major (transposed) or row-major (pass-through), selectable per block, on a valid/ready read stream.
- Writer fills one bank while the reader drains the other, so the DCT pipeline streams without stalls.

---
 rtl/transpose_pingpong_buffer.sv | 148 ++++++++++++++
 tb/tb_transpose_pingpong_buffer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/transpose_pingpong_buffer.sv
`default_nettype none
// ============================================================================
// Module   : transpose_pingpong_buffer
// Purpose  : Two-bank ping-pong buffer between the row and column 1-D DCT
//            passes. Accepts an N x N block row-major on a valid/ready write
//            stream. Returns it either transposed (column-major) or in
//            row-major order on a valid/ready read stream. The order is
//            chosen per block. The writer fills one bank while the reader
//            drains the other.
// Ports    :
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   wr_valid     write word present
//   wr_ready     buffer can take the write word
//   wr_data      write word, block word index r*N+c
//   wr_transpose block mode (1 = transpose), sampled on word 0 of a block
//   rd_valid     rd_data holds a valid word
//   rd_ready     consumer accepts rd_data
//   rd_data      read word (registered)
//   rd_last      final word of a block, qualified by rd_valid
//   blocks_full  number of complete banks not yet fully fetched (0..2)
// Revision : 1.0 - initial release
// ============================================================================
module transpose_pingpong_buffer #(
  parameter int DATA_W = 24,
  parameter int N      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_transpose,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic [1:0]        blocks_full
);

  localparam int                c_HALF_W   = $clog2(N);
  localparam int                c_ADDR_W   = 2 * c_HALF_W;
  localparam int                c_WORDS    = N * N;
  localparam logic [c_ADDR_W-1:0] c_CNT_LAST = '1;

  // Both banks share one array; the bank index is the address MSB.
  logic [DATA_W-1:0]   r_mem [0:2*c_WORDS-1];

  logic [1:0]          r_full;
  logic [1:0]          r_mode;
  logic                r_wr_bank;
  logic [c_ADDR_W-1:0] r_wr_cnt;
  logic                r_rd_bank;
  logic [c_ADDR_W-1:0] r_rd_cnt;
  logic                r_rd_valid;
  logic [DATA_W-1:0]   r_rd_data;
  logic                r_rd_last;

  logic                w_wr_ready;
  logic                w_wr_fire;
  logic                w_wr_last;
  logic                w_fetch;
  logic                w_rd_end;
  logic [c_ADDR_W-1:0] w_rd_addr;
  logic [1:0]          w_full_set;
  logic [1:0]          w_full_clr;

  // The writer may only touch a bank that is not holding a complete block.
  assign w_wr_ready = !r_full[r_wr_bank];
  assign w_wr_fire  = wr_valid && w_wr_ready;
  assign w_wr_last  = (r_wr_cnt == c_CNT_LAST);

  // Fetch whenever a full bank exists and the output register is free or
  // being consumed this cycle.
  assign w_fetch  = r_full[r_rd_bank] && (!r_rd_valid || rd_ready);
  assign w_rd_end = (r_rd_cnt == c_CNT_LAST);

  // Transposed read: swapping the row/column halves of the counter turns
  // (row, col) into (col, row).
  assign w_rd_addr = r_mode[r_rd_bank]
                   ? {r_rd_cnt[c_HALF_W-1:0], r_rd_cnt[c_ADDR_W-1:c_HALF_W]}
                   : r_rd_cnt;

  // Writer sets and reader clears never target the same bank in one cycle,
  // so set/clear on opposite banks combine cleanly.
  assign w_full_set = (w_wr_fire && w_wr_last) ? (2'b01 << r_wr_bank) : 2'b00;
  assign w_full_clr = (w_fetch && w_rd_end)    ? (2'b01 << r_rd_bank) : 2'b00;

  // Storage has no reset.
  always_ff @(posedge clk) begin
    if (w_wr_fire) begin
      r_mem[{r_wr_bank, r_wr_cnt}] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_full     <= 2'b00;
      r_mode     <= 2'b00;
      r_wr_bank  <= 1'b0;
      r_wr_cnt   <= '0;
      r_rd_bank  <= 1'b0;
      r_rd_cnt   <= '0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_rd_last  <= 1'b0;
    end else begin
      r_full <= (r_full | w_full_set) & ~w_full_clr;

      // Write side
      if (w_wr_fire) begin
        if (r_wr_cnt == '0) begin
          r_mode[r_wr_bank] <= wr_transpose;
        end
        if (w_wr_last) begin
          r_wr_bank <= !r_wr_bank;
          r_wr_cnt  <= '0;
        end else begin
          r_wr_cnt  <= r_wr_cnt + c_ADDR_W'(1);
        end
      end

      // Read side
      if (w_fetch) begin
        r_rd_data  <= r_mem[{r_rd_bank, w_rd_addr}];
        r_rd_valid <= 1'b1;
        r_rd_last  <= w_rd_end;
        if (w_rd_end) begin
          r_rd_bank <= !r_rd_bank;
          r_rd_cnt  <= '0;
        end else begin
          r_rd_cnt  <= r_rd_cnt + c_ADDR_W'(1);
        end
      end else if (rd_ready) begin
        r_rd_valid <= 1'b0;
        r_rd_last  <= 1'b0;
      end
    end
  end

  assign wr_ready    = w_wr_ready;
  assign rd_valid    = r_rd_valid;
  assign rd_data     = r_rd_data;
  assign rd_last     = r_rd_last;
  assign blocks_full = {1'b0, r_full[0]} + {1'b0, r_full[1]};

endmodule
`default_nettype wire

// File: tb/tb_transpose_pingpong_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_transpose_pingpong_buffer
// Purpose  : Self-checking bench for transpose_pingpong_buffer. Uses an
//            N=8/24-bit instance and an N=4/16-bit instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_transpose_pingpong_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;

  // N=8, DATA_W=24 instance
  logic        wr_valid, wr_ready, wr_transpose;
  logic [23:0] wr_data;
  logic        rd_valid, rd_ready, rd_last;
  logic [23:0] rd_data;
  logic [1:0]  blocks_full;

  // N=4, DATA_W=16 instance
  logic        wr_valid4, wr_ready4, wr_transpose4;
  logic [15:0] wr_data4;
  logic        rd_valid4, rd_ready4, rd_last4;
  logic [15:0] rd_data4;
  logic [1:0]  blocks_full4;

  transpose_pingpong_buffer #(.DATA_W(24), .N(8)) dut8 (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .wr_transpose(wr_transpose),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .rd_last(rd_last), .blocks_full(blocks_full)
  );

  transpose_pingpong_buffer #(.DATA_W(16), .N(4)) dut4 (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid4), .wr_ready(wr_ready4), .wr_data(wr_data4),
    .wr_transpose(wr_transpose4),
    .rd_valid(rd_valid4), .rd_ready(rd_ready4), .rd_data(rd_data4),
    .rd_last(rd_last4), .blocks_full(blocks_full4)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- reference model for the N=8 instance ----------------
  typedef struct {
    logic [23:0] d;
    bit          last;
    int          pos;
  } exp_t;

  exp_t        exp_q[$];
  logic [23:0] m_blk [0:63];
  int          m_wcnt   = 0;
  bit          m_mode   = 0;
  int          m_acc    = 0;
  int          m_blocks = 0;
  logic [23:0] gdata    = 24'd0;
  bit          probe_en = 0;
  bit          stall_pend = 0;
  logic [23:0] held_d;
  logic        held_l;

  task automatic model_write(input logic [23:0] d, input bit wt);
    if (m_wcnt == 0) m_mode = wt;
    m_blk[m_wcnt] = d;
    m_wcnt++;
    m_acc++;
    if (m_wcnt == 64) begin
      m_wcnt = 0;
      m_blocks++;
      for (int o = 0; o < 64; o++) begin
        exp_t e;
        int   r, c;
        if (m_mode) begin c = o / 8; r = o % 8; end
        else        begin r = o / 8; c = o % 8; end
        e.d    = m_blk[r*8 + c];
        e.last = (o == 63);
        e.pos  = o;
        exp_q.push_back(e);
      end
    end
  endtask

  function automatic bit pick_wt(input int msel);
    if (msel == 2) return bit'(m_blocks % 2);
    return bit'(msel);
  endfunction

  function automatic bit pick_rr(input int rsel);
    if (rsel == 2) return bit'($urandom_range(0, 1));
    return bit'(rsel);
  endfunction

  // One cycle: drive inputs at the falling edge, account for the handshakes
  // that will complete at the next rising edge, then wait a cycle.
  task automatic step8(input bit wv, input bit wt, input bit rr);
    exp_t e;
    wr_valid     = wv;
    wr_data      = gdata;
    wr_transpose = wt;
    rd_ready     = rr;
    if (stall_pend) begin
      check_val("stall_valid", rd_valid, 1);
      check_val("stall_data", rd_data, held_d);
      check_val("stall_last", rd_last, held_l);
    end
    stall_pend = rd_valid && !rr;
    held_d     = rd_data;
    held_l     = rd_last;
    if (rd_valid && rr) begin
      if (exp_q.size() == 0) begin
        check_val("extra_read", rd_valid, 0);
      end else begin
        e = exp_q.pop_front();
        check_val("rd_data", rd_data, e.d);
        check_val("rd_last", rd_last, e.last);
        if (probe_en && e.pos == 62) check_val("wr_ready_before_end", wr_ready, 0);
        if (probe_en && e.pos == 63) begin
          check_val("wr_ready_after_end", wr_ready, 1);
          probe_en = 0;
        end
      end
    end
    if (wv && wr_ready) begin
      model_write(gdata, wt);
      gdata++;
    end
    @(negedge clk);
  endtask

  task automatic write_words(input int n, input int msel, input int rsel);
    int target = m_acc + n;
    int budget = 0;
    while (m_acc < target && budget < 3000) begin
      step8(1'b1, pick_wt(msel), pick_rr(rsel));
      budget++;
    end
    if (m_acc < target) check_val("write_timeout", m_acc, target);
    wr_valid = 1'b0;
  endtask

  task automatic drain(input int rsel);
    int budget = 0;
    while ((exp_q.size() > 0 || rd_valid) && budget < 3000) begin
      step8(1'b0, 1'b0, pick_rr(rsel));
      budget++;
    end
    check_val("drain_empty", exp_q.size(), 0);
  endtask

  // Expected order for the N=4 transposed block of values 0..15
  logic [15:0] exp4 [16] = '{16'd0, 16'd4, 16'd8,  16'd12, 16'd1, 16'd5, 16'd9,  16'd13,
                             16'd2, 16'd6, 16'd10, 16'd14, 16'd3, 16'd7, 16'd11, 16'd15};

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int a0;
    int i4, k4;
    rst = 1'b1;
    wr_valid = 0; wr_data = 0; wr_transpose = 0; rd_ready = 0;
    wr_valid4 = 0; wr_data4 = 0; wr_transpose4 = 0; rd_ready4 = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check_val("rst_rd_valid", rd_valid, 0);
    check_val("rst_rd_last", rd_last, 0);
    check_val("rst_rd_data", rd_data, 0);
    check_val("rst_blocks_full", blocks_full, 0);
    check_val("rst_wr_ready", wr_ready, 1);

    // Transposed block, back-to-back, consumer always ready
    write_words(64, 1, 1);
    check_val("lat_not_early", rd_valid, 0);
    check_val("bf_one", blocks_full, 1);
    step8(1'b0, 1'b0, 1'b1);
    check_val("lat_first", rd_valid, 1);
    drain(1);
    check_val("bf_zero_t", blocks_full, 0);

    // Pass-through block
    write_words(64, 0, 1);
    drain(1);
    check_val("bf_zero_p", blocks_full, 0);

    // Back-pressure: reader stalled, writer streaming
    a0 = m_acc;
    for (int c = 0; c < 140; c++) step8(1'b1, 1'b1, 1'b0);
    check_val("bp_accepted", m_acc - a0, 128);
    check_val("bp_blocks_full", blocks_full, 2);
    check_val("bp_wr_ready", wr_ready, 0);
    probe_en = 1;
    write_words(64, 1, 1);
    drain(1);
    check_val("bp_probe_seen", probe_en, 0);

    // Random read back-pressure with alternating modes
    write_words(256, 2, 2);
    drain(2);

    // Reset with one block buffered and 30 words of the next written
    write_words(94, 0, 0);
    rst = 1'b1; wr_valid = 0; rd_ready = 0;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    m_wcnt = 0;
    stall_pend = 0;
    check_val("mid_rst_rd_valid", rd_valid, 0);
    check_val("mid_rst_blocks_full", blocks_full, 0);
    check_val("mid_rst_wr_ready", wr_ready, 1);
    gdata = 24'h800000;
    write_words(64, 0, 1);
    drain(1);
    check_val("post_rst_bf", blocks_full, 0);

    // N=4 transposed block
    i4 = 0;
    k4 = 0;
    for (int c = 0; c < 50; c++) begin
      wr_valid4     = (i4 < 16);
      wr_data4      = 16'(i4);
      wr_transpose4 = 1'b1;
      rd_ready4     = 1'b1;
      if (rd_valid4 && rd_ready4) begin
        if (k4 < 16) begin
          check_val("n4_data", rd_data4, exp4[k4]);
          check_val("n4_last", rd_last4, (k4 == 15) ? 1 : 0);
        end else begin
          check_val("n4_extra", rd_valid4, 0);
        end
        k4++;
      end
      if (wr_valid4 && wr_ready4) i4++;
      @(negedge clk);
    end
    check_val("n4_count", k4, 16);
    check_val("n4_blocks_full", blocks_full4, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
